commit_unit: RTL
================

COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameters RP, 4, physical copies per architectural register.
REQ-002 SHALL have parameters RB, 2, slot-index width (log2 RP).
REQ-003 SHALL have parameters ROB_DEPTH, 8, reorder-buffer entries (power of 2).
REQ-004 SHALL have parameters FLUSH_HOLD, 2, cycles dispatch stays blocked after flush.
REQ-005 SHALL have ports CLK  in  1  sole clock, rising edge.
REQ-006 SHALL have ports RST  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports rob_push_valid  in  1  dispatch offers an entry.
REQ-008 SHALL have ports rob_push_ready  out  1  entry accepted when valid&ready.
REQ-009 SHALL have ports rob_push_rd  in  5  architectural destination (0 = none).
REQ-010 SHALL have ports rob_push_rdp  in  RB  renamed slot of rd.
REQ-011 SHALL have ports rob_push_except  in  1  entry raises exception at commit.
REQ-012 SHALL have ports wbLog_qout  in  32*RP  writeback-done bits, [RP*rd+slot].
REQ-013 SHALL have ports archi_X_qout  in  RB*32  committed slot per architectural register.
REQ-014 SHALL have ports archi_X_dnxt  out  RB*32  next committed slot map.
REQ-015 SHALL have ports rnBufU_commit_rst  out  32*RP  one-hot free mask for rename-used bits.
REQ-016 SHALL have ports wbLog_commit_rst  out  32*RP  one-hot clear mask for writeback bits.
REQ-017 SHALL have ports flush  out  1  pipeline flush pulse.
REQ-018 SHALL have ports commit_valid  out  1  one entry retired this cycle.
REQ-019 SHALL have ports commit_rd  out  5  rd of retired entry.

Function
REQ-020 SHALL hold entries in a circular ROB: head/tail pointers of log2(ROB_DEPTH)+1 bits; empty when equal, full when only MSB differs; wrap modulo ROB_DEPTH.
REQ-021 SHALL push on rob_push_valid&rob_push_ready at tail; rob_push_ready = !full && state==RUN.
REQ-022 SHALL define head ready = ROB non-empty and (rd==0 or wbLog_qout[RP*rd+rdp]==1).
REQ-023 SHALL, when head ready and not except, in the same cycle: commit_valid=1, commit_rd=rd, archi_X_dnxt equal to archi_X_qout with field rd replaced by rdp, rnBufU_commit_rst and wbLog_commit_rst one-hot at [RP*rd + archi_X_qout[rd]] (previous slot freed), head advances at next edge.
REQ-024 SHALL, with rd==0, retire without altering archi_X_dnxt and with both masks zero.
REQ-025 SHALL otherwise drive archi_X_dnxt = archi_X_qout and both masks zero; at most one retirement per cycle.
REQ-026 SHALL use FSM RUN, FLUSH, HOLD: RUN->FLUSH when head ready and except; FLUSH lasts one cycle with flush=1, commit_valid=0, ROB cleared (head=tail=0) at its edge; FLUSH->HOLD; HOLD counts FLUSH_HOLD cycles then ->RUN.
REQ-027 SHALL give simultaneous push and retire both effect, occupancy unchanged; a push coinciding with the FLUSH cycle is refused (ready=0).
REQ-028 SHALL keep the excepting entry unretired (no archi update, masks zero).

Reset
REQ-029 SHALL, on RST high at a rising edge, set head=tail=0, state=RUN, hold counter=0; outputs then flush=0, commit_valid=0, commit_rd=0, masks zero, rob_push_ready=1, archi_X_dnxt=archi_X_qout.
REQ-030 SHALL let RST asserted mid-FLUSH or mid-HOLD abort to RUN with empty ROB; RST overrides push and retire.

Configuration
REQ-031 SHALL with COMMIT_PERF_CNT_EN defined add outputs perf_retired (64) and perf_flush (64), counting commit_valid and flush pulses, reset to 0, wrap at 2^64; without it these ports and counters are absent and behaviour otherwise identical.

Structure
REQ-032 SHALL take RP/RB from the shared define header; ROB entry typedef {rd, rdp, except} and FSM state encoding in shared package commit_pkg.
REQ-033 SHALL implement storage/pointers in sub-module rob_fifo (push, pop, clear, full, empty, head data); commit logic and FSM in commit_unit.

Verification
REQ-034 SHALL push rd=5,rdp=1; archi[5]=0; set wbLog[21] -> same cycle commit_valid=1, archi_X_dnxt[5]=1, both masks bit 20 only.
REQ-035 SHALL push 8 entries without writeback -> rob_push_ready=0 after 8th; retire one -> ready=1 next cycle.
REQ-036 SHALL push rd=3 except=1, writeback set -> flush=1 one cycle, no archi change, ready low 1+FLUSH_HOLD=3 cycles, ROB empty.
REQ-037 SHALL push rd=0 entry -> retires immediately after push, masks zero, archi unchanged.
REQ-038 SHALL assert RST during HOLD -> next cycle state RUN, ready=1, flush=0.
REQ-039 SHALL, with COMMIT_PERF_CNT_EN, retire 10 entries and 1 flush -> perf_retired=10, perf_flush=1.

Source files
------------

// File: rtl/commit_pkg.sv
// Shared definitions for the commit unit: register-file geometry, ROB entry
// layout, FSM state encoding and a bit-index helper for the per-slot masks.
package commit_pkg;

    // Physical copies per architectural register and the slot-index width
    localparam int COMMIT_RP = 4;
    localparam int COMMIT_RB = 2;

    // One reorder-buffer entry: destination, renamed slot, exception flag
    typedef struct packed {
        logic [4:0]           rd;
        logic [COMMIT_RB-1:0] rdp;
        logic                 except;
    } rob_entry_t;

    // Commit FSM: normal retirement, one-cycle flush, post-flush dispatch block
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } commit_state_e;

    // Flat bit position of (register, slot) in the RP-bits-per-register vectors
    function automatic int slot_bit_idx(input int rp, input int rd, input int slot);
        return (rp * rd) + slot;
    endfunction

endpackage

// File: rtl/commit_unit_rob_fifo.sv
// Circular reorder buffer: entry storage plus head/tail pointers that carry
// one extra wrap bit so that full and empty can be told apart.
module rob_fifo
    import commit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rob_entry_t push_data,
    input  logic       pop,
    input  logic       clear,
    output logic       full,
    output logic       empty,
    output rob_entry_t head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    rob_entry_t    mem_q [DEPTH];
    rob_entry_t    mem_d [DEPTH];

    assign empty     = (head_q == tail_q);
    assign full      = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
    assign head_data = mem_q[head_q[AW-1:0]];

    // Next pointer/storage state: clear wins over push and pop
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (clear) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[tail_q[AW-1:0]] = push_data;
                tail_d                = tail_q + PW'(1'b1);
            end else begin
                tail_d = tail_q;
            end
            if (pop && !empty) begin
                head_d = head_q + PW'(1'b1);
            end else begin
                head_d = head_q;
            end
        end
    end

    // Pointer and storage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head once its writeback is logged,
// updates the committed slot map, frees the previous physical slot, and
// flushes the pipeline when the head carries an exception.
// Optional build macro COMMIT_PERF_CNT_EN adds retire/flush event counters.
module commit_unit
    import commit_pkg::*;
#(
    parameter int RP         = COMMIT_RP,
    parameter int RB         = COMMIT_RB,
    parameter int ROB_DEPTH  = 8,
    parameter int FLUSH_HOLD = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            rob_push_valid,
    output logic            rob_push_ready,
    input  logic [4:0]      rob_push_rd,
    input  logic [RB-1:0]   rob_push_rdp,
    input  logic            rob_push_except,
    input  logic [32*RP-1:0] wbLog_qout,
    input  logic [RB*32-1:0] archi_X_qout,
    output logic [RB*32-1:0] archi_X_dnxt,
    output logic [32*RP-1:0] rnBufU_commit_rst,
    output logic [32*RP-1:0] wbLog_commit_rst,
    output logic            flush,
    output logic            commit_valid,
    output logic [4:0]      commit_rd
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [63:0]     perf_retired,
    output logic [63:0]     perf_flush
`endif
);

    localparam int HCW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam int IW  = $clog2(32 * RP);

    commit_state_e  state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

    rob_entry_t    head_s;
    rob_entry_t    push_entry_s;
    logic          full_s;
    logic          empty_s;
    logic          run_s;
    logic          head_ready_s;
    logic          retire_s;
    logic          flush_start_s;
    logic [RB-1:0] prev_slot_s;
    logic [IW-1:0] wb_idx_s;
    logic [IW-1:0] free_idx_s;

    assign run_s        = (state_q == ST_RUN);
    assign push_entry_s = '{rd: rob_push_rd, rdp: rob_push_rdp, except: rob_push_except};

    rob_fifo #(
        .DEPTH (ROB_DEPTH)
    ) u_rob (
        .clk       (CLK),
        .rst       (RST),
        .push      (rob_push_valid && rob_push_ready),
        .push_data (push_entry_s),
        .pop       (retire_s),
        .clear     (state_q == ST_FLUSH),
        .full      (full_s),
        .empty     (empty_s),
        .head_data (head_s)
    );

    // Head readiness and the retire / flush decision for this cycle
    always_comb begin
        prev_slot_s   = archi_X_qout[RB*int'(head_s.rd) +: RB];
        wb_idx_s      = IW'(slot_bit_idx(RP, int'(head_s.rd), int'(head_s.rdp)));
        free_idx_s    = IW'(slot_bit_idx(RP, int'(head_s.rd), int'(prev_slot_s)));
        head_ready_s  = !empty_s && ((head_s.rd == 5'd0) || wbLog_qout[wb_idx_s]);
        retire_s      = run_s && !RST && head_ready_s && !head_s.except;
        flush_start_s = run_s && !RST && head_ready_s && head_s.except;
    end

    // Retirement outputs: slot-map update and one-hot free masks
    always_comb begin
        archi_X_dnxt      = archi_X_qout;
        rnBufU_commit_rst = '0;
        wbLog_commit_rst  = '0;
        commit_valid      = retire_s;
        commit_rd         = 5'd0;
        if (retire_s) begin
            commit_rd = head_s.rd;
            if (head_s.rd != 5'd0) begin
                archi_X_dnxt[RB*int'(head_s.rd) +: RB] = head_s.rdp;
                rnBufU_commit_rst[free_idx_s]          = 1'b1;
                wbLog_commit_rst[free_idx_s]           = 1'b1;
            end else begin
                commit_rd = 5'd0;
            end
        end else begin
            commit_rd = 5'd0;
        end
    end

    assign rob_push_ready = run_s && !full_s && !RST;
    assign flush          = (state_q == ST_FLUSH);

    // FSM next state: RUN -> FLUSH on excepting head, FLUSH -> HOLD -> RUN
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_start_s) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                hold_cnt_d = '0;
                if (FLUSH_HOLD == 0) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HCW'(FLUSH_HOLD - 1)) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1'b1);
                end
            end
            default: begin
                state_d    = ST_RUN;
                hold_cnt_d = '0;
            end
        endcase
    end

    // FSM state and hold counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] perf_retired_q, perf_retired_d;
    logic [63:0] perf_flush_q, perf_flush_d;

    // Event counter increments, wrapping naturally at 2^64
    always_comb begin
        perf_retired_d = perf_retired_q;
        perf_flush_d   = perf_flush_q;
        if (commit_valid) begin
            perf_retired_d = perf_retired_q + 64'd1;
        end else begin
            perf_retired_d = perf_retired_q;
        end
        if (flush) begin
            perf_flush_d = perf_flush_q + 64'd1;
        end else begin
            perf_flush_d = perf_flush_q;
        end
    end

    // Event counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_retired_q <= 64'd0;
            perf_flush_q   <= 64'd0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_flush_q   <= perf_flush_d;
        end
    end

    assign perf_retired = perf_retired_q;
    assign perf_flush   = perf_flush_q;
`endif

endmodule
